// File: rtl/direct_fir_pkg.sv
// Shared FIR constants and helpers.
// Width defaults, product width and output range reduction.
package direct_fir_pkg;

  localparam int DIN0_W = 18;
  localparam int DIN1_W = 10;
  localparam int DOUT_W = 27;
  localparam int ACC_W  = 40;
  localparam int RW     = 64;

  typedef struct packed {
    logic          ovf;
    logic [RW-1:0] val;
  } red_t;

  function automatic int pw(input int a, input int b);
    return a + b;
  endfunction

  function automatic red_t reduce(
    input logic signed [RW-1:0] r,
    input int                   w,
    input logic                 sat
  );
    logic signed [RW-1:0] hi;
    logic signed [RW-1:0] lo;
    red_t                 o;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    o.ovf = (r > hi) || (r < lo);
    o.val = r;
    if (sat && o.ovf)
      o.val = (r < lo) ? lo : hi;
    return o;
  endfunction

endpackage

// File: rtl/direct_fir_mul_pipe.sv
// Signed x unsigned product with NUM_STAGE gated registers.
// Valid/first/last sidebands travel alongside the product.
module direct_fir_mul_pipe
  import direct_fir_pkg::*;
#(
  parameter int DIN0_WIDTH = DIN0_W,
  parameter int DIN1_WIDTH = DIN1_W,
  parameter int NUM_STAGE  = 2,
  parameter int PW         = pw(DIN0_WIDTH, DIN1_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic signed [PW-1:0]  out_prod,
  output logic                  out_first,
  output logic                  out_last
);

  logic signed [PW-1:0] prod;
  logic [NUM_STAGE-1:0] v;
  logic [NUM_STAGE-1:0] f;
  logic [NUM_STAGE-1:0] l;
  logic signed [PW-1:0] p [NUM_STAGE];

  assign prod = PW'($signed(din0))
              * PW'($signed({1'b0, din1}));

  // Shift the product and sidebands one stage per enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      f <= '0;
      l <= '0;
      for (int k = 0; k < NUM_STAGE; k++)
        p[k] <= '0;
    end else if (en) begin
      v[0] <= in_valid;
      f[0] <= in_first;
      l[0] <= in_last;
      p[0] <= prod;
      for (int k = 1; k < NUM_STAGE; k++) begin
        v[k] <= v[k-1];
        f[k] <= f[k-1];
        l[k] <= l[k-1];
        p[k] <= p[k-1];
      end
    end
  end

  assign out_valid = v[NUM_STAGE-1];
  assign out_first = f[NUM_STAGE-1];
  assign out_last  = l[NUM_STAGE-1];
  assign out_prod  = p[NUM_STAGE-1];

endmodule

// File: rtl/direct_fir_mac_pipe.sv
// Pipelined MAC: product pipe, accumulator, output register.
// Define DIRECT_FIR_MAC_SAT_EN to clamp instead of wrap.
module direct_fir_mac_pipe
  import direct_fir_pkg::*;
#(
  parameter int DIN0_WIDTH = DIN0_W,
  parameter int DIN1_WIDTH = DIN1_W,
  parameter int DOUT_WIDTH = DOUT_W,
  parameter int ACC_WIDTH  = ACC_W,
  parameter int NUM_STAGE  = 2,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_ovf
);

  localparam int PW = pw(DIN0_WIDTH, DIN1_WIDTH);

`ifdef DIRECT_FIR_MAC_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic                        en;
  logic                        p_valid;
  logic signed [PW-1:0]        p_prod;
  logic                        p_first;
  logic                        p_last;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] r;
  logic                        restart;
  red_t                        red;
  logic                        unused_hi;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  direct_fir_mul_pipe #(
    .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_mul (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .en       (en),
    .in_valid (in_valid),
    .din0     (din0),
    .din1     (din1),
    .in_first (in_first),
    .in_last  (in_last),
    .out_valid(p_valid),
    .out_prod (p_prod),
    .out_first(p_first),
    .out_last (p_last)
  );

  assign prod_ext  = ACC_WIDTH'(p_prod);
  assign acc_next  = (p_first || restart)
                   ? prod_ext : acc + prod_ext;
  assign r         = acc_next >>> OUT_SHIFT;
  assign red       = reduce(RW'(r), DOUT_WIDTH, SAT);
  assign unused_hi = ^red.val[RW-1:DOUT_WIDTH];

  // Accumulate; a beat after a last restarts the sum.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc     <= '0;
      restart <= 1'b1;
    end else if (en && p_valid) begin
      acc     <= acc_next;
      restart <= p_last;
    end
  end

  // Load the reduced result on a last beat; hold while stalled.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= p_valid && p_last;
      if (p_valid && p_last) begin
        dout    <= red.val[DOUT_WIDTH-1:0];
        out_ovf <= red.ovf;
      end
    end
  end

endmodule

// File: doc/direct_fir_mac_pipe.md
Name: direct_fir_mac_pipe

Overview:
- Parametrised, pipelined signed×unsigned multiply-accumulate unit for the direct-form FIR datapath.
- Multiplies a signed sample by an unsigned coefficient through NUM_STAGE product registers.
- Accumulates products across one tap sequence, delimited by in_first and in_last.
- Emits one rounded-down, width-reduced result per sequence over a valid/ready stream.
- Successor to the single-cycle combinational multiplier: adds depth, accumulation and back-pressure.

Parameters:
- DIN0_WIDTH, 18, signed sample width
- DIN1_WIDTH, 10, unsigned coefficient width
- DOUT_WIDTH, 27, output width
- ACC_WIDTH, 40, accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH
- NUM_STAGE, 2, product pipeline registers, legal range 1..4
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before width reduction

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- din0  in  DIN0_WIDTH  sample, two's complement
- din1  in  DIN1_WIDTH  coefficient, unsigned
- in_first  in  1  beat starts a new accumulation
- in_last  in  1  beat ends the accumulation; result is emitted
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- dout  out  DOUT_WIDTH  result, two's complement
- out_ovf  out  1  result exceeded DOUT_WIDTH range; qualified by out_valid

Behaviour:
- Reset (ap_rst_n=0 at a rising edge): all stage valids, accumulator, dout, out_valid and out_ovf go to 0. Reset has priority over every other event.
- Arithmetic:
  - product = $signed(din0) * $signed({1'b0,din1}), width PW = DIN0_WIDTH+DIN1_WIDTH, exact.
  - product is sign-extended to ACC_WIDTH.
  - Accumulator wraps modulo 2^ACC_WIDTH; sizing ACC_WIDTH is the integrator's job.
- Flow control:
  - Global enable en = !out_valid || out_ready.
  - in_ready = en. All pipeline registers advance only when en=1.
  - Bubbles (in_valid=0) propagate as invalid stages.
- Pipeline: stage k holds {valid, product, first, last}; the product is formed combinationally before stage 1.
- Accumulate stage, on en with the final product stage valid:
  - acc <= restart ? prod : acc + prod.
  - restart = first || previous accepted beat carried last, so a beat following a last is an implicit first.
  - Initial state after reset is restart=1.
- Output register, on en:
  - out_valid <= final stage valid && last.
  - When loading: r = (acc_next >>> OUT_SHIFT); dout <= r reduced to DOUT_WIDTH; out_ovf <= r outside signed DOUT_WIDTH range.
  - When out_valid=1 && out_ready=0: dout, out_valid and out_ovf hold stable.
- Latency: an accepted last beat produces out_valid exactly NUM_STAGE+1 cycles later with no stall; each stall cycle adds one.
- Throughput: one beat per cycle while out_ready=1.
- Boundary cases:
  - first && last on the same beat: single-product result.
  - first mid-sequence: discards the partial sum.
  - last with an empty pipeline ahead of it: normal.
  - Reset mid-sequence: partial sum is lost and the next beat is treated as first.

Optional Feature:
- Macro: DIRECT_FIR_MAC_SAT_EN.
- Defined: an out-of-range r clamps to +(2^(DOUT_WIDTH-1))-1 or -(2^(DOUT_WIDTH-1)); out_ovf reports the clamp.
- Undefined: dout = r[DOUT_WIDTH-1:0] (two's-complement wrap); out_ovf is still computed and reported.

Decomposition:
- Package direct_fir_pkg holds:
  - Default width constants (18/10/27/40).
  - A function for the PW width.
  - A function reduce(r, sat) returning {ovf, value}, shared with other FIR blocks.
- Sub-module direct_fir_mul_pipe: product formation plus NUM_STAGE enable-gated registers carrying valid/first/last sidebands.
- Accumulator and output register stay in the top module.

Test Plan (defaults: NUM_STAGE=2, OUT_SHIFT=0):
- Single product: din0=-5, din1=7, first=last=1, out_ready=1 -> out_valid 3 cycles later, dout=-35, out_ovf=0.
- Accumulation: 4 beats din0={1,2,3,4}, din1=10, first on beat 0, last on beat 3 -> one result, dout=100; back-to-back second sequence {-1,-1} x 3 -> dout=-6.
- Overflow: din0=-131072, din1=1023, first=last=1 -> out_ovf=1; dout=-67108864 with DIRECT_FIR_MAC_SAT_EN, dout=131072 without.
- Back-pressure: out_ready=0 while a result is pending -> in_ready=0 next cycle, dout and out_valid stable for 5 held cycles; release -> no beat lost or duplicated.
- Reset mid-sequence: beats din0={100,100}, din1=1 (first on beat 0), then ap_rst_n=0 for 1 cycle, then din0=3, din1=2, last=1 with no first -> dout=6.
- Bubbles: in_valid toggling 1/0 through the 4-beat sequence -> dout=100 and latency measured from the last beat = 3.
